// File: rtl/pw_unlock_ctrl.sv
// Password-sequence unlock controller: compares debounced button presses against a
// compile-time code, with bounded attempts, a timed lockout, progress LEDs and relock.
module pw_unlock_ctrl #(
    parameter int NBTN        = 4,
    parameter int CODE_LEN    = 4,
    parameter int IW          = $clog2(NBTN),
    parameter logic [CODE_LEN*IW-1:0] PW_CODE = 8'hE4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 100000000,
    parameter int TW          = $clog2(MAX_TRIES + 1)
) (
    input  logic                CLKIN,
    input  logic                RESET,
    input  logic [NBTN-1:0]     BTN,
    input  logic                CLEAR,
    input  logic                RELOCK,
    output logic                DECENABLE,
    output logic                LOCKED,
    output logic [CODE_LEN-1:0] LEDOUT,
    output logic [TW-1:0]       TRIES_LEFT
);

    localparam int IDXW = $clog2(CODE_LEN + 1);
    localparam int TMW  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {
        ENTRY    = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } state_t;

    state_t          state;
    logic [NBTN-1:0] btn_q;
    logic [IDXW-1:0] idx;
    logic            mis;
    logic [TW-1:0]   tries;
    logic [TMW-1:0]  timer;

    logic [NBTN-1:0] rise;
    logic            press;
    logic            multi;
    logic [IW-1:0]   press_idx;
    logic [IW-1:0]   exp_btn;
    logic            mis_next;
    logic            last;

    function automatic logic [CODE_LEN-1:0] therm(input logic [IDXW-1:0] n);
        logic [CODE_LEN-1:0] t;
        t = '0;
        for (int j = 0; j < CODE_LEN; j++) begin
            t[j] = (IDXW'(j) < n);
        end
        return t;
    endfunction

    always_comb begin
        rise      = BTN & ~btn_q;
        press     = |rise;
        // more than one new button in the same cycle can never match a single code digit
        multi     = (rise & (rise - NBTN'(1))) != '0;
        press_idx = '0;
        for (int i = 0; i < NBTN; i++) begin
            if (rise[i]) press_idx = IW'(i);
        end
        exp_btn = '0;
        for (int k = 0; k < CODE_LEN; k++) begin
            if (idx == IDXW'(k)) exp_btn = PW_CODE[k*IW +: IW];
        end
        mis_next = mis | multi | (press_idx != exp_btn);
        last     = (idx == IDXW'(CODE_LEN - 1));
    end

    assign TRIES_LEFT = tries;

    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            state     <= ENTRY;
            btn_q     <= '0;
            idx       <= '0;
            mis       <= 1'b0;
            tries     <= TW'(MAX_TRIES);
            timer     <= '0;
            DECENABLE <= 1'b0;
            LOCKED    <= 1'b0;
            LEDOUT    <= '0;
        end else begin
            btn_q <= BTN;
            case (state)
                ENTRY: begin
                    if (CLEAR) begin
                        idx    <= '0;
                        mis    <= 1'b0;
                        LEDOUT <= '0;
                    end else if (press) begin
                        if (last) begin
                            idx <= '0;
                            mis <= 1'b0;
                            if (!mis_next) begin
                                state     <= UNLOCKED;
                                tries     <= TW'(MAX_TRIES);
                                DECENABLE <= 1'b1;
                                LEDOUT    <= '1;
                            end else if (tries > TW'(1)) begin
                                tries  <= tries - TW'(1);
                                LEDOUT <= '0;
                            end else begin
                                state  <= LOCKOUT;
                                tries  <= '0;
                                timer  <= '0;
                                LOCKED <= 1'b1;
                                LEDOUT <= '0;
                            end
                        end else begin
                            idx    <= idx + IDXW'(1);
                            mis    <= mis_next;
                            LEDOUT <= therm(idx + IDXW'(1));
                        end
                    end
                end
                UNLOCKED: begin
                    if (RELOCK) begin
                        state     <= ENTRY;
                        idx       <= '0;
                        mis       <= 1'b0;
                        DECENABLE <= 1'b0;
                        LEDOUT    <= '0;
                    end
                end
                LOCKOUT: begin
                    if (timer == TMW'(LOCK_CYCLES - 1)) begin
                        state  <= ENTRY;
                        tries  <= TW'(MAX_TRIES);
                        idx    <= '0;
                        mis    <= 1'b0;
                        LOCKED <= 1'b0;
                        LEDOUT <= '0;
                    end else begin
                        timer <= timer + TMW'(1);
                    end
                end
                default: begin
                    state     <= ENTRY;
                    idx       <= '0;
                    mis       <= 1'b0;
                    DECENABLE <= 1'b0;
                    LOCKED    <= 1'b0;
                    LEDOUT    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pw_unlock_ctrl.sv
// Scoreboard bench for pw_unlock_ctrl: stimulus queues cycle-stamped expected outputs,
// a negedge monitor pops and compares them when their cycle comes up.
module tb_pw_unlock_ctrl;

    logic       CLKIN = 1'b0;
    logic       RESET;
    logic [3:0] BTN;
    logic       CLEAR;
    logic       RELOCK;
    logic       DECENABLE;
    logic       LOCKED;
    logic [3:0] LEDOUT;
    logic [1:0] TRIES_LEFT;

    pw_unlock_ctrl #(
        .NBTN(4), .CODE_LEN(4), .PW_CODE(8'hE4), .MAX_TRIES(3), .LOCK_CYCLES(16)
    ) dut (
        .CLKIN(CLKIN), .RESET(RESET), .BTN(BTN), .CLEAR(CLEAR), .RELOCK(RELOCK),
        .DECENABLE(DECENABLE), .LOCKED(LOCKED), .LEDOUT(LEDOUT), .TRIES_LEFT(TRIES_LEFT)
    );

    always #5 CLKIN = ~CLKIN;

    typedef struct {
        int         cyc;
        string      nm;
        logic       dec;
        logic       lck;
        logic [3:0] led;
        logic [1:0] tries;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always @(posedge CLKIN) cyc <= cyc + 1;

    initial begin
        exp_t e;
        forever begin
            @(negedge CLKIN);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_chk++;
                if (e.cyc < cyc) begin
                    $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.nm, e.cyc, cyc);
                end else if (DECENABLE === e.dec && LOCKED === e.lck &&
                             LEDOUT === e.led && TRIES_LEFT === e.tries) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s @cyc %0d: got dec=%b lck=%b led=%b tries=%0d, want dec=%b lck=%b led=%b tries=%0d",
                             e.nm, cyc, DECENABLE, LOCKED, LEDOUT, TRIES_LEFT, e.dec, e.lck, e.led, e.tries);
                end
            end
        end
    end

    task automatic push(input int at, input string nm, input logic dec, input logic lck,
                        input logic [3:0] led, input logic [1:0] tries);
        exp_t e;
        e.cyc = at; e.nm = nm; e.dec = dec; e.lck = lck; e.led = led; e.tries = tries;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(negedge CLKIN);
    endtask

    // drive a one-cycle press, expect the outputs right after its edge, then leave a gap
    task automatic press(input logic [3:0] b, input string nm, input logic dec, input logic lck,
                         input logic [3:0] led, input logic [1:0] tries);
        BTN = b;
        push(cyc + 1, nm, dec, lck, led, tries);
        tick();
        BTN = 4'b0000;
        tick();
    endtask

    task automatic enter3(input logic [3:0] b0, input logic [3:0] b1, input logic [3:0] b2,
                          input logic [1:0] t, input string nm);
        press(b0, {nm, "_p1"}, 1'b0, 1'b0, 4'b0001, t);
        press(b1, {nm, "_p2"}, 1'b0, 1'b0, 4'b0011, t);
        press(b2, {nm, "_p3"}, 1'b0, 1'b0, 4'b0111, t);
    endtask

    task automatic unlock(input logic [1:0] t, input string nm);
        enter3(4'b0001, 4'b0010, 4'b0100, t, nm);
        press(4'b1000, {nm, "_unlock"}, 1'b1, 1'b0, 4'b1111, 2'd3);
    endtask

    task automatic relock(input string nm);
        RELOCK = 1'b1;
        push(cyc + 1, nm, 1'b0, 1'b0, 4'b0000, 2'd3);
        tick();
        RELOCK = 1'b0;
        tick();
    endtask

    task automatic async_reset(input string nm);
        @(posedge CLKIN);
        #2;
        RESET = 1'b1;
        push(cyc, nm, 1'b0, 1'b0, 4'b0000, 2'd3);
        tick();
        RESET = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; BTN = 4'b0000; CLEAR = 1'b0; RELOCK = 1'b0;
        tick();
        push(cyc + 1, "reset", 1'b0, 1'b0, 4'b0000, 2'd3);
        tick();
        RESET = 1'b0;
        tick();

        // correct entry, pressed while unlocked is ignored, then relock
        unlock(2'd3, "ok");
        press(4'b0001, "unl_ignore", 1'b1, 1'b0, 4'b1111, 2'd3);
        relock("relock1");

        // wrong then right
        enter3(4'b0001, 4'b0010, 4'b1000, 2'd3, "wrong");
        press(4'b0100, "wrong_end", 1'b0, 1'b0, 4'b0000, 2'd2);
        unlock(2'd2, "right");
        relock("relock2");

        // three wrong entries lead to lockout
        enter3(4'b1000, 4'b1000, 4'b1000, 2'd3, "bad1");
        press(4'b1000, "bad1_end", 1'b0, 1'b0, 4'b0000, 2'd2);
        enter3(4'b1000, 4'b1000, 4'b1000, 2'd2, "bad2");
        press(4'b1000, "bad2_end", 1'b0, 1'b0, 4'b0000, 2'd1);
        enter3(4'b1000, 4'b1000, 4'b1000, 2'd1, "bad3");
        BTN = 4'b1000;
        push(cyc + 1, "lock_enter", 1'b0, 1'b1, 4'b0000, 2'd0);
        tick();
        BTN = 4'b0000;
        for (int i = 2; i <= 17; i++) begin
            if (i < 15) BTN = (i % 2 == 1) ? 4'b0001 : 4'b0000;
            else        BTN = 4'b0001;
            if (i <= 16) push(cyc + 1, "lock_hold", 1'b0, 1'b1, 4'b0000, 2'd0);
            else         push(cyc + 1, "lock_exit", 1'b0, 1'b0, 4'b0000, 2'd3);
            tick();
        end
        push(cyc + 1, "held_exit1", 1'b0, 1'b0, 4'b0000, 2'd3);
        tick();
        push(cyc + 1, "held_exit2", 1'b0, 1'b0, 4'b0000, 2'd3);
        tick();
        BTN = 4'b0000;
        tick();
        unlock(2'd3, "after_lock");
        relock("relock3");

        // CLEAR together with a press: press discarded, no attempt used
        press(4'b0001, "clr_p1", 1'b0, 1'b0, 4'b0001, 2'd3);
        press(4'b0010, "clr_p2", 1'b0, 1'b0, 4'b0011, 2'd3);
        BTN = 4'b0100; CLEAR = 1'b1;
        push(cyc + 1, "clear", 1'b0, 1'b0, 4'b0000, 2'd3);
        tick();
        BTN = 4'b0000; CLEAR = 1'b0;
        tick();
        unlock(2'd3, "after_clr");
        relock("relock4");

        // two buttons rising together count as one mismatching press
        enter3(4'b0011, 4'b0010, 4'b0100, 2'd3, "multi");
        press(4'b1000, "multi_end", 1'b0, 1'b0, 4'b0000, 2'd2);

        // a held button is one press
        BTN = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            push(cyc + 1, "held", 1'b0, 1'b0, 4'b0001, 2'd2);
            tick();
        end
        BTN = 4'b0000;
        tick();
        press(4'b0010, "held_p2", 1'b0, 1'b0, 4'b0011, 2'd2);
        press(4'b0100, "held_p3", 1'b0, 1'b0, 4'b0111, 2'd2);
        press(4'b1000, "held_unlock", 1'b1, 1'b0, 4'b1111, 2'd3);

        // reset while unlocked, mid-entry and mid-lockout
        async_reset("rst_unlocked");
        press(4'b0001, "rst_p1", 1'b0, 1'b0, 4'b0001, 2'd3);
        press(4'b0010, "rst_p2", 1'b0, 1'b0, 4'b0011, 2'd3);
        async_reset("rst_entry");
        unlock(2'd3, "after_rst");
        relock("relock5");
        for (int n = 0; n < 3; n++) begin
            enter3(4'b0100, 4'b0100, 4'b0100, 2'(3 - n), "lk");
            press(4'b0100, "lk_end", 1'b0, (n == 2), 4'b0000, 2'(2 - n));
        end
        repeat (4) tick();
        async_reset("rst_lockout");
        unlock(2'd3, "after_rst_lock");

        repeat (3) tick();
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
